// File: rtl/inst_sched_if.sv
// Instruction scheduler port bundle: switch/strobe inputs, datapath and UART status, issue outputs.
// No latency (wires only); flow control is strobe/pulse based, no ready path.
// drop_cnt exists only when INST_SCHED_DROPCNT_EN is defined.
interface inst_sched_if #(parameter int DEPTH = 4);
    localparam int CW = $clog2(DEPTH) + 1;

    logic [7:0]    sw_inst;
    logic          inst_stb;
    logic          tx_busy;
    logic          mult_done;
    logic          inst_vld;
    logic [7:0]    inst_wd;
    logic [CW-1:0] fifo_cnt;
    logic          drop;
    logic          tmo_err;
`ifdef INST_SCHED_DROPCNT_EN
    logic [7:0]    drop_cnt;
`endif

    modport master (
`ifdef INST_SCHED_DROPCNT_EN
        input  drop_cnt,
`endif
        output sw_inst, inst_stb, tx_busy, mult_done,
        input  inst_vld, inst_wd, fifo_cnt, drop, tmo_err
    );

    modport slave (
`ifdef INST_SCHED_DROPCNT_EN
        output drop_cnt,
`endif
        input  sw_inst, inst_stb, tx_busy, mult_done,
        output inst_vld, inst_wd, fifo_cnt, drop, tmo_err
    );
endinterface

// File: rtl/inst_sched.sv
// Instruction scheduler: DEPTH-entry FIFO feeding a 4-state issue FSM (SEND waits UART, MULT waits datapath).
// Latency: strobe on edge n into an empty FIFO issues in cycle n+2; tmo_err fires MUL_TMO cycles after a MULT issue.
// Backpressure: none upstream; strobes into a full FIFO are dropped and flagged (drop_cnt with INST_SCHED_DROPCNT_EN).
module inst_sched #(
    parameter int DEPTH   = 4,
    parameter int MUL_TMO = 16
) (
    input  logic       clk,
    input  logic       rst,
    inst_sched_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [1:0] OP_MULT = 2'b10;
    localparam logic [1:0] OP_SEND = 2'b11;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT_TX, WAIT_MUL} state_t;

    state_t        state, state_nxt;
    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] cnt;
    logic [7:0]    wd_q;
    logic [7:0]    tmr;
    logic [7:0]    head;
    logic          drop_q;
    logic          full, push, pop, tmo;

    // Fullness uses the registered count, so a same-edge pop never rescues a strobe.
    assign full = (cnt == CW'(DEPTH));
    assign push = bus.inst_stb && !full;
    assign pop  = (state == ISSUE);
    assign head = mem[rd_ptr];

    always_comb begin
        state_nxt = state;
        tmo       = 1'b0;
        case (state)
            IDLE: begin
                if (cnt != '0 && (head[7:6] != OP_SEND || !bus.tx_busy))
                    state_nxt = ISSUE;
            end
            ISSUE: begin
                case (wd_q[7:6])
                    OP_SEND: state_nxt = WAIT_TX;
                    OP_MULT: state_nxt = WAIT_MUL;
                    default: state_nxt = IDLE;
                endcase
            end
            WAIT_TX: begin
                // tmr marks that the unconditional first cycle has passed
                if (tmr != 8'd0 && !bus.tx_busy)
                    state_nxt = IDLE;
            end
            WAIT_MUL: begin
                if (bus.mult_done) begin
                    state_nxt = IDLE;
                end else if (tmr == 8'(MUL_TMO - 1)) begin
                    state_nxt = IDLE;
                    tmo       = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
            wd_q   <= 8'h00;
            tmr    <= 8'd0;
            drop_q <= 1'b0;
        end else begin
            state  <= state_nxt;
            drop_q <= bus.inst_stb && full;
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
            if (state == IDLE && state_nxt == ISSUE)
                wd_q <= head;
            if (state == WAIT_TX)
                tmr <= 8'd1;
            else if (state == WAIT_MUL)
                tmr <= tmr + 8'd1;
            else
                tmr <= 8'd0;
        end
    end

    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= bus.sw_inst;
    end

`ifdef INST_SCHED_DROPCNT_EN
    logic [7:0] drop_cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            drop_cnt_q <= 8'h00;
        else if (bus.inst_stb && full && drop_cnt_q != 8'hFF)
            drop_cnt_q <= drop_cnt_q + 8'h01;
    end

    assign bus.drop_cnt = drop_cnt_q;
`endif

    assign bus.inst_vld = (state == ISSUE);
    assign bus.inst_wd  = wd_q;
    assign bus.fifo_cnt = cnt;
    assign bus.drop     = drop_q;
    assign bus.tmo_err  = (state == WAIT_MUL) && tmo;
endmodule

// File: tb/tb_inst_sched.sv
// Directed bench for inst_sched: issue latency, FIFO full/drop, SEND/MULT waits, timeout, mid-run reset.
// Inputs change 1 time unit after the rising edge; outputs are sampled there too.
module tb_inst_sched;
    localparam int DEPTH   = 4;
    localparam int MUL_TMO = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   tests  = 0;
    int   failed = 0;

    inst_sched_if #(.DEPTH(DEPTH)) bus ();

    inst_sched #(.DEPTH(DEPTH), .MUL_TMO(MUL_TMO)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            failed++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic strobe(input logic [7:0] w);
        bus.sw_inst  = w;
        bus.inst_stb = 1'b1;
        tick();
        bus.inst_stb = 1'b0;
    endtask

    task automatic wait_issue(input string tag, input logic [7:0] exp);
        int n = 0;
        while (!bus.inst_vld && n < 40) begin
            tick();
            n++;
        end
        chk({tag, "_vld"}, {31'd0, bus.inst_vld}, 32'd1);
        chk({tag, "_wd"}, {24'd0, bus.inst_wd}, {24'd0, exp});
        tick();
        chk({tag, "_pulse"}, {31'd0, bus.inst_vld}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] full_seq [5];
        logic       seen;
        int         n;

        full_seq[0] = 8'hC0; full_seq[1] = 8'h05; full_seq[2] = 8'h46;
        full_seq[3] = 8'h07; full_seq[4] = 8'h08;
        bus.sw_inst   = 8'h00;
        bus.inst_stb  = 1'b0;
        bus.tx_busy   = 1'b0;
        bus.mult_done = 1'b0;

        // reset state
        tick(); tick();
        chk("rst_cnt", {29'd0, bus.fifo_cnt}, 32'd0);
        chk("rst_vld", {31'd0, bus.inst_vld}, 32'd0);
        chk("rst_wd", {24'd0, bus.inst_wd}, 32'h00);
        chk("rst_drop", {31'd0, bus.drop}, 32'd0);
        chk("rst_tmo", {31'd0, bus.tmo_err}, 32'd0);
`ifdef INST_SCHED_DROPCNT_EN
        chk("rst_dcnt", {24'd0, bus.drop_cnt}, 32'd0);
`endif
        rst = 1'b0;
        tick();

        // single PUSH: issue two cycles after the strobe edge
        strobe(8'h14);
        chk("push_cnt1", {29'd0, bus.fifo_cnt}, 32'd1);
        chk("push_early", {31'd0, bus.inst_vld}, 32'd0);
        tick();
        chk("push_vld", {31'd0, bus.inst_vld}, 32'd1);
        chk("push_wd", {24'd0, bus.inst_wd}, 32'h14);
        tick();
        chk("push_pulse", {31'd0, bus.inst_vld}, 32'd0);
        chk("push_cnt0", {29'd0, bus.fifo_cnt}, 32'd0);
        chk("push_hold", {24'd0, bus.inst_wd}, 32'h14);

        // fill behind a blocked SEND, fifth strobe dropped
        bus.tx_busy = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 5; i++) begin
            strobe(full_seq[i]);
            seen |= bus.inst_vld;
        end
        chk("full_cnt", {29'd0, bus.fifo_cnt}, 32'd4);
        chk("full_drop", {31'd0, bus.drop}, 32'd1);
        for (int i = 0; i < 3; i++) begin
            tick();
            seen |= bus.inst_vld;
        end
        chk("full_noiss", {31'd0, seen}, 32'd0);
        chk("drop_pulse", {31'd0, bus.drop}, 32'd0);
        bus.tx_busy = 1'b0;
        wait_issue("send", 8'hC0);
        wait_issue("fifo1", 8'h05);
        wait_issue("fifo2", 8'h46);
        wait_issue("fifo3", 8'h07);
        tick();
        chk("drain_cnt", {29'd0, bus.fifo_cnt}, 32'd0);

        // MULT completed by mult_done, then queued ADD issues
        strobe(8'h9B);
        strobe(8'h46);
        wait_issue("mul", 8'h9B);
        seen = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            seen |= bus.inst_vld;
        end
        chk("mul_hold", {31'd0, seen}, 32'd0);
        bus.mult_done = 1'b1;
        chk("mul_notmo", {31'd0, bus.tmo_err}, 32'd0);
        tick();
        bus.mult_done = 1'b0;
        wait_issue("add", 8'h46);
        chk("add_tmo", {31'd0, bus.tmo_err}, 32'd0);

        // MULT timeout
        strobe(8'h9B);
        wait_issue("mul_t", 8'h9B);
        n = 0;
        while (!bus.tmo_err && n < 100) begin
            tick();
            n++;
        end
        chk("tmo_lat", n, MUL_TMO - 1);
        tick();
        chk("tmo_pulse", {31'd0, bus.tmo_err}, 32'd0);
        bus.mult_done = 1'b1;
        tick();
        bus.mult_done = 1'b0;
        chk("late_done_vld", {31'd0, bus.inst_vld}, 32'd0);
        chk("late_done_tmo", {31'd0, bus.tmo_err}, 32'd0);
        strobe(8'h21);
        chk("idle_early", {31'd0, bus.inst_vld}, 32'd0);
        tick();
        chk("idle_vld", {31'd0, bus.inst_vld}, 32'd1);
        chk("idle_wd", {24'd0, bus.inst_wd}, 32'h21);
        tick();

        // reset during WAIT_MUL with entries queued, strobe held through reset
        strobe(8'h9B);
        strobe(8'h46);
        strobe(8'h05);
        chk("q3_cnt", {29'd0, bus.fifo_cnt}, 32'd2);
        tick(); tick();
        rst = 1'b1;
        bus.sw_inst  = 8'h11;
        bus.inst_stb = 1'b1;
        #1;
        chk("arst_cnt", {29'd0, bus.fifo_cnt}, 32'd0);
        chk("arst_wd", {24'd0, bus.inst_wd}, 32'h00);
        chk("arst_vld", {31'd0, bus.inst_vld}, 32'd0);
        tick(); tick();
        rst = 1'b0;
        bus.inst_stb = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            seen |= bus.inst_vld;
        end
        chk("post_rst_noiss", {31'd0, seen}, 32'd0);
        chk("post_rst_cnt", {29'd0, bus.fifo_cnt}, 32'd0);

`ifdef INST_SCHED_DROPCNT_EN
        // saturating drop counter
        bus.tx_busy = 1'b1;
        for (int i = 0; i < 300; i++)
            strobe(8'hC0);
        tick();
        chk("dcnt_sat", {24'd0, bus.drop_cnt}, 32'hFF);
        bus.tx_busy = 1'b0;
`endif

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule
